// File: rtl/oric_mem_pkg.sv
// rtl/oric_mem_pkg.sv - shared types and defaults for the Oric RAM arbiter
package oric_mem_pkg;

  localparam int         AW_DEFAULT        = 16;
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/oric_ram_arbiter_if.sv
// rtl/oric_ram_arbiter_if.sv - RAM-side bus between arbiter and external RAM
// Ports (signals): mem_addr/mem_din/mem_we driven by the arbiter (master),
// mem_q returned by the RAM one cycle after mem_addr (slave).
interface oric_ram_arbiter_if
  import oric_mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) ();

  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_q;

  modport master (output mem_addr, output mem_din, output mem_we, input mem_q);
  modport slave  (input mem_addr, input mem_din, input mem_we, output mem_q);

endinterface

// File: rtl/oric_ram_clr_cnt.sv
// rtl/oric_ram_clr_cnt.sv - clear address generator
// Ports: clk_sys/RESET (sync, active-high), en advances the count,
// cnt is the current clear address, tc flags the last address (all ones).
module oric_ram_clr_cnt
  import oric_mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          tc
);

  // Wraps back to zero after the last address, so a finished clear leaves
  // the counter ready for the next one.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/oric_ram_arbiter.sv
// rtl/oric_ram_arbiter.sv - RAM owner arbitration between clear, loader and CPU
// Ports: clk_sys, RESET (sync, active-high);
// CPU side cpu_cs/cpu_we/cpu_addr/cpu_din in, cpu_q/cpu_wait out;
// loader side ld_start/ld_wr/ld_addr/ld_data/ld_end in, ld_ack/ld_busy out;
// clr_busy out; mem (master) carries mem_addr/mem_din/mem_we out, mem_q in.
module oric_ram_arbiter
  import oric_mem_pkg::*;
#(
  parameter logic [7:0] FILL_BYTE = FILL_BYTE_DEFAULT,
  parameter int         AW        = AW_DEFAULT
) (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_q,
  output logic          cpu_wait,
  input  logic          ld_start,
  input  logic          ld_wr,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  input  logic          ld_end,
  output logic          ld_ack,
  output logic          ld_busy,
  output logic          clr_busy,
  oric_ram_arbiter_if.master mem
);

  arb_state_t    state_q, state_d;
  logic          pend_q, pend_d;
  logic          ack_q;
  logic [7:0]    hold_q;
  logic          clr_en;
  logic [AW-1:0] clr_cnt;
  logic          clr_tc;
  logic [AW-1:0] addr_d;
  logic [7:0]    din_d;
  logic          we_d;

  oric_ram_clr_cnt #(.AW(AW)) u_clr_cnt (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .en      (clr_en),
    .cnt     (clr_cnt),
    .tc      (clr_tc)
  );

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q <= CLEAR;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ack_q   <= (state_q == LOAD) && ld_wr;
      // Track what the CPU sees so it can be frozen while the loader owns RAM.
      if (state_q == RUN) begin
        hold_q <= mem.mem_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    addr_d  = cpu_addr;
    din_d   = cpu_din;
    we_d    = 1'b0;
    clr_en  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        addr_d = clr_cnt;
        din_d  = FILL_BYTE;
        we_d   = 1'b1;
        clr_en = 1'b1;
        if (ld_start) begin
          pend_d = 1'b1;
        end
        // A start seen in the final clear cycle counts as pending too.
        if (clr_tc) begin
          state_d = (pend_q || ld_start) ? LOAD : RUN;
          pend_d  = 1'b0;
        end
      end
      RUN: begin
        we_d = cpu_cs & cpu_we;
        if (ld_start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        addr_d = ld_addr;
        din_d  = ld_data;
        we_d   = ld_wr;
        if (ld_end) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    // No RAM write while reset is held, so the clear length is counted from release.
    if (RESET) begin
      we_d = 1'b0;
    end
  end

  assign mem.mem_addr = addr_d;
  assign mem.mem_din  = din_d;
  assign mem.mem_we   = we_d;

  assign cpu_q    = (state_q == RUN) ? mem.mem_q : hold_q;
  assign cpu_wait = RESET || (state_q != RUN);
  assign ld_busy  = !RESET && (state_q == LOAD);
  assign clr_busy = RESET || (state_q == CLEAR);
  assign ld_ack   = ack_q;

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// tb/tb_oric_ram_arbiter.sv - self-checking bench for oric_ram_arbiter
module tb_oric_ram_arbiter;
  import oric_mem_pkg::*;

  localparam int         AW    = 16;
  localparam int         DEPTH = 1 << AW;
  localparam logic [7:0] FILL  = 8'hFF;
  localparam int         M_CLR = 0;
  localparam int         M_RUN = 1;
  localparam int         M_LD  = 2;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          RESET;
  logic          cpu_cs, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_q;
  logic          cpu_wait;
  logic          ld_start, ld_wr, ld_end;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          ld_ack, ld_busy, clr_busy;

  oric_ram_arbiter_if #(.AW(AW)) mem_bus ();

  oric_ram_arbiter #(.FILL_BYTE(FILL), .AW(AW)) dut (
    .clk_sys  (clk_sys),
    .RESET    (RESET),
    .cpu_cs   (cpu_cs),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_q    (cpu_q),
    .cpu_wait (cpu_wait),
    .ld_start (ld_start),
    .ld_wr    (ld_wr),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .ld_end   (ld_end),
    .ld_ack   (ld_ack),
    .ld_busy  (ld_busy),
    .clr_busy (clr_busy),
    .mem      (mem_bus.master)
  );

  // External RAM, read-first, one cycle read latency.
  logic [7:0] ram [DEPTH];
  always @(posedge clk_sys) begin
    mem_bus.mem_q <= ram[mem_bus.mem_addr];
    if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_din;
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM, expected RAM contents, and what the CPU sees.
  int            m_mode;
  int            m_idx;
  bit            m_pend;
  logic          m_ack;
  logic [7:0]    m_mq, m_hold, nxt_mq;
  logic [7:0]    ref_ram [DEPTH];
  logic [AW-1:0] m_a;

  function automatic logic [AW-1:0] exp_addr();
    if (m_mode == M_CLR) return AW'(m_idx);
    if (m_mode == M_RUN) return cpu_addr;
    return ld_addr;
  endfunction

  function automatic logic [7:0] exp_din();
    if (m_mode == M_CLR) return FILL;
    if (m_mode == M_RUN) return cpu_din;
    return ld_data;
  endfunction

  function automatic logic exp_we();
    if (RESET) return 1'b0;
    if (m_mode == M_CLR) return 1'b1;
    if (m_mode == M_RUN) return cpu_cs && cpu_we;
    return ld_wr;
  endfunction

  always @(posedge clk_sys) begin
    m_a    = exp_addr();
    nxt_mq = ref_ram[m_a];
    if (RESET) begin
      m_mode = M_CLR; m_idx = 0; m_pend = 0; m_ack = 0; m_hold = 8'h00;
    end else begin
      case (m_mode)
        M_CLR: begin
          ref_ram[m_a] = FILL;
          m_ack = 0;
          if (ld_start) m_pend = 1;
          if (m_idx == DEPTH - 1) begin
            m_mode = m_pend ? M_LD : M_RUN;
            m_pend = 0;
            m_idx  = 0;
          end else begin
            m_idx++;
          end
        end
        M_RUN: begin
          m_hold = m_mq;
          m_ack  = 0;
          if (cpu_cs && cpu_we) ref_ram[m_a] = cpu_din;
          if (ld_start) m_mode = M_LD;
        end
        default: begin
          if (ld_wr) ref_ram[m_a] = ld_data;
          m_ack = ld_wr;
          if (ld_end) m_mode = M_RUN;
        end
      endcase
    end
    m_mq = nxt_mq;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("clr_busy", 32'(clr_busy), 32'(RESET || m_mode == M_CLR));
      chk("ld_busy",  32'(ld_busy),  32'(!RESET && m_mode == M_LD));
      chk("cpu_wait", 32'(cpu_wait), 32'(RESET || m_mode != M_RUN));
      chk("ld_ack",   32'(ld_ack),   32'(m_ack));
      chk("mem_we",   32'(mem_bus.mem_we), 32'(exp_we()));
      chk("mem_addr", 32'(mem_bus.mem_addr), 32'(exp_addr()));
      if (exp_we()) chk("mem_din", 32'(mem_bus.mem_din), 32'(exp_din()));
      chk("cpu_q", 32'(cpu_q), 32'((m_mode == M_RUN) ? m_mq : m_hold));
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic idle();
    cpu_cs = 0; cpu_we = 0; cpu_addr = '0; cpu_din = 8'h00;
    ld_start = 0; ld_wr = 0; ld_end = 0; ld_addr = '0; ld_data = 8'h00;
  endtask

  task automatic ld_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ld_wr = 1; ld_addr = a; ld_data = d;
  endtask

  int we_cnt;
  int ack_cnt;
  bit done;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 8'h00;
      ref_ram[i] = 8'h00;
    end
    mem_bus.mem_q = 8'h00;
    idle();
    RESET = 1;
    tick();
    chk_en = 1;
    tick();
    tick();
    #1;
    chk("reset clr_busy", 32'(clr_busy), 32'd1);
    chk("reset ld_busy",  32'(ld_busy),  32'd0);
    chk("reset cpu_wait", 32'(cpu_wait), 32'd1);

    // Full clear with a start request latched part-way through.
    RESET = 0;
    we_cnt = 0;
    done = 0;
    for (int i = 0; i < 70000 && !done; i++) begin
      if (i > 0) tick();
      cpu_cs = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
      ld_start = (i == 30000);
      ld_end = (i < 60000) ? 1'($urandom) : 1'b0;
      ld_wr = 0;
      #1;
      if (!clr_busy) done = 1;
      else if (mem_bus.mem_we) we_cnt++;
    end
    chk("clear_done", 32'(done), 32'd1);
    chk("clear_len", 32'(we_cnt), 32'd65536);
    chk("load_after_clear ld_busy", 32'(ld_busy), 32'd1);
    chk("load_after_clear cpu_wait", 32'(cpu_wait), 32'd1);
    chk("clear ram[8000]", 32'(ram[16'h8000]), 32'hFF);
    chk("clear ram[FFFF]", 32'(ram[16'hFFFF]), 32'hFF);

    // Three back-to-back loader bytes while the CPU tries to write 0600.
    tick(); idle();
    cpu_cs = 1; cpu_we = 1; cpu_addr = 16'h0600; cpu_din = 8'h77;
    ld_byte(16'h0500, 8'h11);
    #1 chk("ack0 before", 32'(ld_ack), 32'd0);
    tick(); ld_byte(16'h0501, 8'h22);
    #1 chk("ack 0500", 32'(ld_ack), 32'd1);
    tick(); ld_byte(16'h0502, 8'h33);
    #1 chk("ack 0501", 32'(ld_ack), 32'd1);
    tick(); ld_wr = 0;
    #1 chk("ack 0502", 32'(ld_ack), 32'd1);
    chk("load cpu_wait", 32'(cpu_wait), 32'd1);
    tick(); ld_end = 1;
    #1 chk("ack idle", 32'(ld_ack), 32'd0);
    tick(); idle();
    #1 chk("after ld_end cpu_wait", 32'(cpu_wait), 32'd0);
    chk("ram[0500]", 32'(ram[16'h0500]), 32'h11);
    chk("ram[0501]", 32'(ram[16'h0501]), 32'h22);
    chk("ram[0502]", 32'(ram[16'h0502]), 32'h33);
    chk("ram[0600] blocked", 32'(ram[16'h0600]), 32'hFF);

    // CPU write then read-back of 1234.
    tick(); cpu_cs = 1; cpu_we = 1; cpu_addr = 16'h1234; cpu_din = 8'h5A;
    tick(); cpu_we = 0;
    tick(); idle();
    #1 chk("cpu_q 1234", 32'(cpu_q), 32'h5A);
    chk("ram[1234]", 32'(ram[16'h1234]), 32'h5A);

    // Random traffic across RUN and LOAD.
    for (int i = 0; i < 4000; i++) begin
      tick();
      cpu_cs = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = {8'h40, 8'($urandom)}; cpu_din = 8'($urandom);
      ld_start = ($urandom_range(0, 63) == 0);
      ld_end = ($urandom_range(0, 15) == 0);
      ld_wr = 1'($urandom);
      ld_addr = {8'h40, 8'($urandom)}; ld_data = 8'($urandom);
    end

    // Reset in the middle of a loader session.
    tick(); idle(); ld_start = 1;
    tick(); idle();
    #1 chk("session ld_busy", 32'(ld_busy), 32'd1);
    tick(); ld_byte(16'h0700, 8'hA1);
    tick(); ld_byte(16'h0701, 8'hB2);
    tick(); idle();
    tick(); RESET = 1; ld_byte(16'h0702, 8'hC3);
    tick(); RESET = 0;
    #1 chk("abort ld_busy", 32'(ld_busy), 32'd0);
    chk("abort clr_busy", 32'(clr_busy), 32'd1);
    chk("abort restart addr", 32'(mem_bus.mem_addr), 32'h0);
    ack_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      ld_wr = 1'($urandom);
      ld_addr = 16'h0702; ld_data = 8'hC3;
      #1 if (ld_ack) ack_cnt++;
    end
    chk("no ack after abort", 32'(ack_cnt), 32'd0);
    chk("ram[0701] written", 32'(ram[16'h0701]), 32'hB2);
    chk("ram[0702] untouched", 32'(ram[16'h0702]), 32'hFF);

    @(posedge clk_sys);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
